// File: rtl/m216a_top_module.sv
// rtl/m216a_top_module.sv - shelf-packing rectangle placer with fixed 8-cycle result latency
// Build option: STRIKE_SATURATE_EN makes strike_o saturate at 15 instead of wrapping.
module m216a_top_module #(
  parameter int CANVAS_W = 128,
  parameter int CANVAS_H = 128,
  parameter int MAX_DIM  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] height_i,
  input  logic [4:0] width_i,
  output logic [3:0] strike_o,
  output logic [7:0] index_x_o,
  output logic [7:0] index_y_o
);

  localparam int DEPTH = 8;
  localparam logic [9:0] CW = 10'(CANVAS_W);
  localparam logic [9:0] CH = 10'(CANVAS_H);
  localparam logic [5:0] MD = 6'(MAX_DIM);

  typedef struct packed {
    logic       vld;
    logic       strike;
    logic [7:0] x;
    logic [7:0] y;
  } res_t;

  logic [1:0] frame_q, frame_d;
  logic [7:0] shelf_y_q, shelf_y_d;
  logic [4:0] shelf_h_q, shelf_h_d;
  logic [7:0] cur_x_q, cur_x_d;
  res_t       pipe_q [DEPTH];
  res_t       pipe_d [DEPTH];
  logic [3:0] strike_q, strike_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  logic       sample, idle, legal, fit, fresh;
  logic [9:0] sum_x, ny, sum_y;
  res_t       new_res;

  always_comb begin
    frame_d   = frame_q + 2'd1;
    shelf_y_d = shelf_y_q;
    shelf_h_d = shelf_h_q;
    cur_x_d   = cur_x_q;
    sample    = (frame_q == 2'd0);
    idle      = (height_i == 5'd0) && (width_i == 5'd0);
    legal     = (height_i != 5'd0) && (width_i != 5'd0) &&
                ({1'b0, height_i} <= MD) && ({1'b0, width_i} <= MD);

    // 10-bit sums keep cur_x+w and ny+h from wrapping near the canvas edge
    sum_x = {2'b00, cur_x_q} + {5'd0, width_i};
    fit   = legal && (cur_x_q != 8'd0) && (height_i <= shelf_h_q) && (sum_x <= CW);
    ny    = (cur_x_q != 8'd0) ? ({2'b00, shelf_y_q} + {5'd0, shelf_h_q}) : {2'b00, shelf_y_q};
    sum_y = ny + {5'd0, height_i};
    fresh = legal && !fit && (sum_y <= CH);

    new_res.vld    = sample && !idle;
    new_res.strike = !(fit || fresh);
    new_res.x      = 8'h80;
    new_res.y      = 8'h80;
    if (fit) begin
      new_res.x = cur_x_q;
      new_res.y = shelf_y_q;
    end else if (fresh) begin
      new_res.x = 8'd0;
      new_res.y = ny[7:0];
    end

    if (sample && fit) begin
      cur_x_d = sum_x[7:0];
    end else if (sample && fresh) begin
      shelf_y_d = ny[7:0];
      shelf_h_d = height_i;
      cur_x_d   = {3'd0, width_i};
    end

    // Every request walks the full delay line so latency is outcome-independent
    pipe_d[0] = new_res;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];

    strike_d = strike_q;
    x_d      = x_q;
    y_d      = y_q;
    if (pipe_q[DEPTH-1].vld) begin
      x_d = pipe_q[DEPTH-1].x;
      y_d = pipe_q[DEPTH-1].y;
      if (pipe_q[DEPTH-1].strike) begin
`ifdef STRIKE_SATURATE_EN
        if (strike_q != 4'hf) strike_d = strike_q + 4'd1;
`else
        strike_d = strike_q + 4'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q   <= 2'd0;
      shelf_y_q <= 8'd0;
      shelf_h_q <= 5'd0;
      cur_x_q   <= 8'd0;
      strike_q  <= 4'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      frame_q   <= frame_d;
      shelf_y_q <= shelf_y_d;
      shelf_h_q <= shelf_h_d;
      cur_x_q   <= cur_x_d;
      strike_q  <= strike_d;
      x_q       <= x_d;
      y_q       <= y_d;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign strike_o  = strike_q;
  assign index_x_o = x_q;
  assign index_y_o = y_q;

endmodule

// File: tb/tb_m216a_top_module.sv
// tb/tb_m216a_top_module.sv - scoreboard bench for m216a_top_module with a shelf-packing reference model
module tb_m216a_top_module;

  logic       clk;
  logic       rst;
  logic [4:0] height_i;
  logic [4:0] width_i;
  logic [3:0] strike_o;
  logic [7:0] index_x_o;
  logic [7:0] index_y_o;

  m216a_top_module dut (
    .clk       (clk),
    .rst       (rst),
    .height_i  (height_i),
    .width_i   (width_i),
    .strike_o  (strike_o),
    .index_x_o (index_x_o),
    .index_y_o (index_y_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int x;
    int y;
    int s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   exp_x = 0;
  int   exp_y = 0;
  int   exp_s = 0;
  int   m_sy = 0, m_sh = 0, m_cx = 0, m_st = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: results become current on their due edge and must hold until the next one
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      if (sb[0].due < cyc) chk("late_pop", sb[0].due, cyc);
      exp_x = sb[0].x;
      exp_y = sb[0].y;
      exp_s = sb[0].s;
      void'(sb.pop_front());
    end
    if (rst) begin
      chk("index_x", int'(index_x_o), exp_x);
      chk("index_y", int'(index_y_o), exp_y);
      chk("strike",  int'(strike_o),  exp_s);
    end
  end

  task automatic model_strike();
`ifdef STRIKE_SATURATE_EN
    if (m_st < 15) m_st++;
`else
    m_st = (m_st + 1) % 16;
`endif
  endtask

  // Called at the falling edge just before a sampling edge; leaves the bench at the next such edge
  task automatic req(input int h, input int w);
    exp_t e;
    int   ny;
    height_i = 5'(h);
    width_i  = 5'(w);
    e.due = cyc + 9;
    if (!(h == 0 && w == 0)) begin
      e.x = 128;
      e.y = 128;
      if (h >= 1 && h <= 16 && w >= 1 && w <= 16) begin
        ny = (m_cx > 0) ? m_sy + m_sh : m_sy;
        if (m_cx > 0 && h <= m_sh && m_cx + w <= 128) begin
          e.x = m_cx;
          e.y = m_sy;
          m_cx += w;
        end else if (ny + h <= 128) begin
          e.x = 0;
          e.y = ny;
          m_sy = ny;
          m_sh = h;
          m_cx = w;
        end else begin
          model_strike();
        end
      end else begin
        model_strike();
      end
      e.s = m_st;
      sb.push_back(e);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    height_i = 5'd0;
    width_i  = 5'd0;
    sb.delete();
    exp_x = 0; exp_y = 0; exp_s = 0;
    m_sy = 0; m_sh = 0; m_cx = 0; m_st = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_x", int'(index_x_o), 0);
    chk("rst_y", int'(index_y_o), 0);
    chk("rst_strike", int'(strike_o), 0);
  endtask

  task automatic rand_req();
    int r, h, w;
    r = $urandom_range(0, 99);
    if (r < 8) begin
      h = 0; w = 0;
    end else if (r < 20) begin
      h = $urandom_range(0, 31);
      w = (h > 16 || h == 0) ? $urandom_range(0, 31) : $urandom_range(17, 31);
      if (h == 0 && w == 0) w = 20;
    end else begin
      h = $urandom_range(1, 16);
      w = $urandom_range(1, 16);
    end
    req(h, w);
  endtask

  initial begin
    rst = 1'b0;
    height_i = 5'd0;
    width_i  = 5'd0;

    do_reset();
    req(4, 8);
    req(0, 0); req(0, 0); req(0, 0);

    do_reset();
    req(4, 8); req(4, 8); req(2, 10);

    do_reset();
    req(4, 8); req(6, 8);

    do_reset();
    for (int i = 0; i < 17; i++) req(4, 8);

    do_reset();
    req(20, 3); req(0, 5); req(0, 0); req(0, 0); req(0, 0);

    do_reset();
    for (int i = 0; i < 65; i++) req(16, 16);
    req(1, 1);

    do_reset();
    for (int i = 0; i < 20; i++) req(31, 31);
    req(0, 0); req(0, 0); req(0, 0);

    // Reset with two requests in flight: neither may surface afterwards
    do_reset();
    req(4, 8); req(3, 3);
    do_reset();
    req(0, 0); req(0, 0); req(0, 0);

    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < 80; i++) rand_req();
    end

    height_i = 5'd0;
    width_i  = 5'd0;
    repeat (12) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/m216a_top_module.md
M216A_TOP_MODULE -- requirements
Module: m216a_top_module

Interface
REQ-001 Parameter CANVAS_W, default 128: canvas width in unit cells.
REQ-002 Parameter CANVAS_H, default 128: canvas height in unit cells.
REQ-003 Parameter MAX_DIM, default 16: largest legal request width or height.
REQ-004 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-low.
REQ-006 Port height_i, input, 5: requested rectangle height.
REQ-007 Port width_i, input, 5: requested rectangle width.
REQ-008 Port strike_o, output, 4: count of rejected requests.
REQ-009 Port index_x_o, output, 8: x of the placed rectangle's lower-left corner.
REQ-010 Port index_y_o, output, 8: y of the placed rectangle's lower-left corner.

Function
REQ-011 The block SHALL run a free-running 2-bit frame counter.
- Counter is 0 on the first rising edge after rst releases.
- Inputs are sampled only on edges where the counter is 0, i.e. one request per 4 cycles.
REQ-012 A request SHALL be treated as follows:
- Idle: h=0 and w=0. No state change, no strike; outputs keep their current values.
- Legal: 1<=h<=MAX_DIM and 1<=w<=MAX_DIM.
- Every other value is illegal.
REQ-013 Shelf state SHALL be shelf_y (8b), shelf_h (5b) and cur_x (8b), all 0 after reset.
REQ-014 Fit on current shelf: if cur_x>0, h<=shelf_h and cur_x+w<=CANVAS_W:
- Place at (cur_x, shelf_y).
- cur_x += w.
REQ-015 Otherwise open a new shelf:
- ny = shelf_y+shelf_h if cur_x>0, else shelf_y.
- If ny+h<=CANVAS_H: place at (0, ny); set shelf_y=ny, shelf_h=h, cur_x=w.
REQ-016 A legal request that fits neither REQ-014 nor REQ-015, and every illegal request, SHALL:
- Be a strike.
- Leave shelf state unchanged.
- Produce index_x_o=index_y_o=128 (0x80).
REQ-017 Comparisons SHALL use at least 9-bit sums so that cur_x+w and ny+h cannot wrap.
REQ-018 Latency: for a request sampled at edge N, index_x_o, index_y_o and strike_o SHALL update on edge N+8.
- They hold for the following 4 cycles.
- Back-to-back requests give results every 4 cycles.
REQ-019 Internal pipeline depth SHALL be fixed so that REQ-018 holds for every request regardless of outcome.
REQ-020 Once the canvas is full, every later legal request SHALL strike; there is no wrap-around or reuse of space.

Reset
REQ-021 While rst=0 at a rising edge, the block SHALL clear:
- strike_o, index_x_o, index_y_o to 0.
- The frame counter, shelf state and all pipeline registers.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight requests; no result from them appears after release.

Configuration
REQ-023 Macro STRIKE_SATURATE_EN:
- Defined: strike_o SHALL saturate at 15.
- Undefined: strike_o SHALL wrap modulo 16 (15+1=0).

Verification
REQ-024 Reset, then (h=4, w=8) -> (0,0) after 8 cycles, strike_o=0.
REQ-025 (4,8), (4,8), (2,10) -> (0,0), (8,0), (16,0) at 4-cycle spacing.
REQ-026 (4,8) then (6,8) -> (0,0), (0,4); the new shelf opens because h>shelf_h.
REQ-027 Seventeen (4,8) requests -> x=0,8,...,120 at y=0, then (0,4).
REQ-028 (20,3), then (0,5) -> both give (128,128), strike_o=2; then (0,0) idle -> outputs and strike unchanged.
REQ-029 Sixty-four (16,16) requests fill the canvas; the 65th -> (128,128), strike increments.
- With STRIKE_SATURATE_EN, 20 illegal requests -> strike_o=15.
